// File: rtl/countdown_scheduler.sv
// Shared dw-bit countdown resource, granted round-robin to one of NREQ requesters at a time.
// Each granted job loads its latched length, counts down to zero and pulses done to its owner.
module countdown_scheduler #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned dw   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*dw-1:0]   req_len,
    input  logic                 pause,
    input  logic                 abort,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic [dw-1:0]        count
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [IW-1:0]      last_q, last_d;
    logic [dw-1:0]      len_q, len_d;
    logic [dw-1:0]      count_q, count_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic               busy_q, busy_d;

    logic               pick_valid;
    logic [IW-1:0]      pick_idx;
    logic [IW:0]        cand;

    // Round-robin search starting just after the last owner; one extra bit avoids overflow
    // before the modulo fold.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!pick_valid && req[cand[IW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IW-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            last_q  <= IW'(NREQ - 1);
            len_q   <= '0;
            count_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            len_q   <= len_d;
            count_q <= count_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        len_d   = len_q;
        count_d = count_q;
        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    idx_d   = pick_idx;
                    len_d   = req_len[pick_idx * dw +: dw];
                    state_d = StLoad;
                end
            end
            StLoad: begin
                count_d = len_q;
                state_d = (len_q == '0) ? StDone : StRun;
            end
            StRun: begin
                if (abort || !req[idx_q]) begin
                    state_d = StIdle;
                    count_d = '0;
                    last_d  = idx_q;
                end else if (!pause) begin
                    if (count_q != '0) begin
                        count_d = count_q - dw'(1);
                    end
                    if (count_q <= dw'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                last_d  = idx_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered, so they are derived from the upcoming state and owner.
    always_comb begin
        gnt_d  = '0;
        done_d = '0;
        busy_d = (state_d != StIdle);
        if (busy_d) begin
            gnt_d[idx_d] = 1'b1;
        end
        if (state_d == StDone) begin
            done_d[idx_d] = 1'b1;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign count = count_q;

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(gnt_q));
    a_done_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(done_q));
    a_done_owned : assert property (@(posedge clk) disable iff (reset)
        ((done_q & ~gnt_q) == '0));

endmodule

// File: tb/tb_countdown_scheduler.sv
// Directed bench for countdown_scheduler: hand-computed per-cycle expectations for each scenario.
module tb_countdown_scheduler;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_len;
    logic            pause;
    logic            abort;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic            busy;
    logic [DW-1:0]   count;

    int checks = 0;
    int errors = 0;

    countdown_scheduler #(
        .NREQ (N),
        .dw   (DW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .req_len (req_len),
        .pause   (pause),
        .abort   (abort),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        pause = 1'b0;
        abort = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_len(input int i, input logic [DW-1:0] v);
        req_len[i*DW +: DW] = v;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_gnt"}, {28'b0, gnt}, 32'd0);
        check({tag, "_done"}, {28'b0, done}, 32'd0);
        check({tag, "_count"}, {24'b0, count}, 32'd0);
    endtask

    initial begin
        req_len = '0;
        do_reset();
        check_idle("rst");

        // Single job, len 3; changing req_len after the grant must not matter.
        set_len(0, 8'd3);
        req = 4'b0001;
        tick();
        check("t1_load_gnt", {28'b0, gnt}, 32'h1);
        check("t1_load_busy", {31'b0, busy}, 32'd1);
        set_len(0, 8'd9);
        tick();
        check("t1_cnt3", {24'b0, count}, 32'd3);
        tick();
        check("t1_cnt2", {24'b0, count}, 32'd2);
        check("t1_nodone", {28'b0, done}, 32'd0);
        tick();
        check("t1_cnt1", {24'b0, count}, 32'd1);
        tick();
        check("t1_cnt0", {24'b0, count}, 32'd0);
        check("t1_done", {28'b0, done}, 32'h1);
        check("t1_done_gnt", {28'b0, gnt}, 32'h1);
        req = 4'b0000;
        tick();
        check_idle("t1_end");

        // All four requesting with len 1: grants rotate 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < 4; i++) set_len(i, 8'd1);
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            tick();
            check("t2_gnt", {28'b0, gnt}, 32'd1 << (j % 4));
            tick();
            check("t2_cnt", {24'b0, count}, 32'd1);
            check("t2_onehot", {31'b0, $onehot(gnt)}, 32'd1);
            tick();
            check("t2_done", {28'b0, done}, 32'd1 << (j % 4));
            check("t2_cnt0", {24'b0, count}, 32'd0);
            tick();
            check("t2_idle_busy", {31'b0, busy}, 32'd0);
            check("t2_idle_done", {28'b0, done}, 32'd0);
        end
        req = 4'b0000;

        // len 0 goes LOAD -> DONE; abort/pause outside RUN are ignored.
        set_len(0, 8'd0);
        req = 4'b0001;
        tick();
        check("t3_load_gnt", {28'b0, gnt}, 32'h1);
        abort = 1'b1;
        pause = 1'b1;
        tick();
        check("t3_done", {28'b0, done}, 32'h1);
        check("t3_cnt", {24'b0, count}, 32'd0);
        abort = 1'b0;
        pause = 1'b0;
        req = 4'b0000;
        tick();
        check_idle("t3_end");

        // len 5 with 3 pause cycles at count 4: done at E9 instead of E6.
        set_len(0, 8'd5);
        req = 4'b0001;
        tick();
        tick();
        check("t4_cnt5", {24'b0, count}, 32'd5);
        tick();
        check("t4_cnt4", {24'b0, count}, 32'd4);
        pause = 1'b1;
        for (int p = 0; p < 3; p++) begin
            tick();
            check("t4_hold", {24'b0, count}, 32'd4);
            check("t4_hold_done", {28'b0, done}, 32'd0);
        end
        pause = 1'b0;
        tick();
        check("t4_cnt3", {24'b0, count}, 32'd3);
        tick();
        tick();
        check("t4_cnt1", {24'b0, count}, 32'd1);
        check("t4_nodone", {28'b0, done}, 32'd0);
        tick();
        check("t4_done", {28'b0, done}, 32'h1);
        req = 4'b0000;
        tick();
        check("t4_end_busy", {31'b0, busy}, 32'd0);

        // len 6, req1 arrives mid-job, abort at count 2; req1 served next.
        do_reset();
        set_len(0, 8'd6);
        set_len(1, 8'd2);
        req = 4'b0001;
        tick();
        tick();
        check("t5_cnt6", {24'b0, count}, 32'd6);
        req = 4'b0011;
        tick();
        check("t5_nopreempt", {28'b0, gnt}, 32'h1);
        tick();
        tick();
        tick();
        check("t5_cnt2", {24'b0, count}, 32'd2);
        abort = 1'b1;
        tick();
        check_idle("t5_abort");
        abort = 1'b0;
        tick();
        check("t5_next_gnt", {28'b0, gnt}, 32'h2);
        tick();
        check("t5_cnt_r1", {24'b0, count}, 32'd2);
        tick();
        tick();
        check("t5_done1", {28'b0, done}, 32'h2);
        req = 4'b0000;
        tick();

        // Reset at count 3 of requester 2's job; pointer returns to priority 0.
        set_len(2, 8'd5);
        req = 4'b0100;
        tick();
        check("t6_gnt2", {28'b0, gnt}, 32'h4);
        tick();
        tick();
        tick();
        check("t6_cnt3", {24'b0, count}, 32'd3);
        reset = 1'b1;
        tick();
        check_idle("t6_reset");
        reset = 1'b0;
        set_len(0, 8'd4);
        req = 4'b0101;
        tick();
        check("t6_rr0", {28'b0, gnt}, 32'h1);

        // pause and abort together in RUN: abort wins.
        tick();
        check("t7_cnt4", {24'b0, count}, 32'd4);
        pause = 1'b1;
        abort = 1'b1;
        tick();
        check_idle("t7_abort");
        pause = 1'b0;
        abort = 1'b0;
        req   = 4'b0000;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
